// File: rtl/mem_timer_pkg.sv
// Shared constants, register-select type and address decode for the memory-mapped machine timer.
// Consumed by mem_timer and its bench; optional macro MEM_TIMER_SNAPSHOT_EN lives in mem_timer.
package mem_timer_pkg;

  localparam logic [4:0] TIMER_MTIME_OFF = 5'h00;
  localparam logic [4:0] TIMER_CMP_OFF   = 5'h08;
  localparam logic [4:0] TIMER_CTRL_OFF  = 5'h10;
  localparam logic [4:0] TIMER_STAT_OFF  = 5'h11;

  localparam int unsigned CTRL_RUN_BIT  = 0;
  localparam int unsigned CTRL_IE_BIT   = 1;
  localparam int unsigned STAT_PEND_BIT = 0;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  // Value of bus address bits [17:15] that selects the timer window at the top level.
  localparam logic [2:0] TIMER_WINDOW = 3'b101;

  typedef enum logic [2:0] {
    REG_MTIME,
    REG_CMP,
    REG_CTRL,
    REG_STAT,
    REG_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_reg(input logic [4:0] off);
    if ((off & 5'h18) == TIMER_MTIME_OFF) return REG_MTIME;
    if ((off & 5'h18) == TIMER_CMP_OFF)   return REG_CMP;
    if (off == TIMER_CTRL_OFF)            return REG_CTRL;
    if (off == TIMER_STAT_OFF)            return REG_STAT;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/mem_timer_if.sv
// Byte-wide CPU memory bus as seen by the timer; master = CPU/decode side, slave = timer.
interface mem_timer_if #(
  parameter int unsigned ADDR_WIDTH = 17
);

  logic                  rdy_in;
  logic                  en_in;
  logic                  r_nw_in;
  logic [ADDR_WIDTH-1:0] a_in;
  logic [7:0]            d_in;
  logic [7:0]            d_out;

  modport master (
    output rdy_in,
    output en_in,
    output r_nw_in,
    output a_in,
    output d_in,
    input  d_out
  );

  modport slave (
    input  rdy_in,
    input  en_in,
    input  r_nw_in,
    input  a_in,
    input  d_in,
    output d_out
  );

endinterface

// File: rtl/mem_timer_prescaler.sv
// timer_prescaler: divides clk by PRESCALE while enabled, emitting a one-cycle tick on wrap.
module timer_prescaler #(
  parameter int unsigned PRESCALE = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  // A divide-by-1 still needs a (constant zero) counter bit.
  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] pcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= (pcnt == LAST) ? '0 : pcnt + CW'(1);
    end
  end

  assign tick = en & (pcnt == LAST);

endmodule

// File: rtl/mem_timer.sv
// Machine timer: 64-bit mtime/mtimecmp, ctrl/status bytes, registered read data and interrupt.
// Define MEM_TIMER_SNAPSHOT_EN for a tear-free shadow of mtime[63:8] captured on reads of byte 0.
module mem_timer
  import mem_timer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned PRESCALE   = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  mem_timer_if.slave bus,
  output logic       timer_interrupt
);

  logic [4:0]  off;
  logic [2:0]  bidx;
  reg_sel_e    sel;
  logic        valid;
  logic        wr;
  logic        rd;
  logic        cnt_en;
  logic        tick;
  logic        pend;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [1:0]  ctrl;
  logic [7:0]  mtime_byte;
  logic [7:0]  rdata;
  logic        unused_addr;

  assign off         = bus.a_in[4:0];
  assign bidx        = off[2:0];
  assign sel         = decode_reg(off);
  assign unused_addr = ^bus.a_in[ADDR_WIDTH-1:5];

  assign valid  = bus.en_in & bus.rdy_in;
  assign wr     = valid & ~bus.r_nw_in;
  assign rd     = valid &  bus.r_nw_in;
  assign cnt_en = ctrl[CTRL_RUN_BIT] & bus.rdy_in;
  assign pend   = (mtime >= mtimecmp);

  timer_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (cnt_en),
    .tick (tick)
  );

  // A byte write to mtime suppresses that cycle's increment entirely (no carry into other bytes).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime <= '0;
    end else if (wr && sel == REG_MTIME) begin
      mtime[{bidx, 3'b000} +: 8] <= bus.d_in;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtimecmp <= MTIMECMP_RST;
    end else if (wr && sel == REG_CMP) begin
      mtimecmp[{bidx, 3'b000} +: 8] <= bus.d_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl <= '0;
    end else if (wr && sel == REG_CTRL) begin
      ctrl <= bus.d_in[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_interrupt <= 1'b0;
    end else if (bus.rdy_in) begin
      timer_interrupt <= ctrl[CTRL_IE_BIT] & pend;
    end
  end

`ifdef MEM_TIMER_SNAPSHOT_EN
  logic [55:0] shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (rd && sel == REG_MTIME && bidx == 3'd0) begin
      shadow <= mtime[63:8];
    end
  end

  always_comb begin
    mtime_byte = mtime[7:0];
    if (bidx != 3'd0) begin
      mtime_byte = shadow[{bidx - 3'd1, 3'b000} +: 8];
    end
  end
`else
  always_comb begin
    mtime_byte = mtime[{bidx, 3'b000} +: 8];
  end
`endif

  always_comb begin
    rdata = '0;
    case (sel)
      REG_MTIME: rdata = mtime_byte;
      REG_CMP:   rdata = mtimecmp[{bidx, 3'b000} +: 8];
      REG_CTRL:  rdata = {6'b0, ctrl};
      REG_STAT:  rdata = {7'b0, pend} << STAT_PEND_BIT;
      default:   rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.d_out <= '0;
    end else if (rd) begin
      bus.d_out <= rdata;
    end
  end

endmodule

// File: tb/tb_mem_timer.sv
// Bench for mem_timer: two instances (PRESCALE 4 and 1) on one shared bus, checked every cycle
// against a behavioural model, plus directed checks from the timer's documented scenarios.
module tb_mem_timer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        rdy = 1'b1;
  logic        rnw = 1'b1;
  logic [16:0] addr = '0;
  logic [7:0]  din = '0;
  logic        irq4;
  logic        irq1;

  int n_asserts = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_timer_if #(.ADDR_WIDTH(17)) bus4 ();
  mem_timer_if #(.ADDR_WIDTH(17)) bus1 ();

  assign bus4.rdy_in = rdy;  assign bus1.rdy_in = rdy;
  assign bus4.en_in = en;    assign bus1.en_in = en;
  assign bus4.r_nw_in = rnw; assign bus1.r_nw_in = rnw;
  assign bus4.a_in = addr;   assign bus1.a_in = addr;
  assign bus4.d_in = din;    assign bus1.d_in = din;

  mem_timer #(.ADDR_WIDTH(17), .PRESCALE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4), .timer_interrupt(irq4)
  );

  mem_timer #(.ADDR_WIDTH(17), .PRESCALE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .timer_interrupt(irq1)
  );

  // Reference model, index 0 = PRESCALE 4, index 1 = PRESCALE 1.
  logic [63:0] m_time [2];
  logic [63:0] m_cmp  [2];
  logic [63:0] m_snap [2];
  logic [1:0]  m_ctrl [2];
  int unsigned m_pcnt [2];
  logic [7:0]  m_dout [2];
  logic        m_irq  [2];

  function automatic int unsigned ps(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_time[k] = 64'd0;
      m_cmp[k]  = 64'hFFFF_FFFF_FFFF_FFFF;
      m_snap[k] = 64'd0;
      m_ctrl[k] = 2'b00;
      m_pcnt[k] = 0;
      m_dout[k] = 8'h00;
      m_irq[k]  = 1'b0;
    end
  endtask

  function automatic logic [7:0] model_read(input int k, input int unsigned o);
    if (o < 8) begin
`ifdef MEM_TIMER_SNAPSHOT_EN
      if (o != 0) return 8'(m_snap[k] >> (8 * o));
`endif
      return 8'(m_time[k] >> (8 * o));
    end
    if (o < 16) return 8'(m_cmp[k] >> (8 * (o - 8)));
    if (o == 16) return {6'b0, m_ctrl[k]};
    if (o == 17) return {7'b0, (m_time[k] >= m_cmp[k])};
    return 8'h00;
  endfunction

  function automatic logic [63:0] put_byte(input logic [63:0] v, input int unsigned i,
                                           input logic [7:0] b);
    return (v & ~(64'hFF << (8 * i))) | (64'(b) << (8 * i));
  endfunction

  task automatic model_step(input int k);
    int unsigned o;
    bit v;
    bit tick;
    logic [7:0] rv;
    o    = int'(addr[4:0]);
    v    = en && rdy;
    rv   = model_read(k, o);
    tick = m_ctrl[k][0] && rdy && (m_pcnt[k] == ps(k) - 1);
    if (rdy) m_irq[k] = m_ctrl[k][1] && (m_time[k] >= m_cmp[k]);
    if (v && rnw) begin
      m_dout[k] = rv;
      if (o == 0) m_snap[k] = m_time[k];
    end
    if (m_ctrl[k][0] && rdy) m_pcnt[k] = (m_pcnt[k] + 1) % ps(k);
    if (v && !rnw && o < 8) m_time[k] = put_byte(m_time[k], o, din);
    else if (tick)          m_time[k] = m_time[k] + 64'd1;
    if (v && !rnw && o >= 8 && o < 16) m_cmp[k] = put_byte(m_cmp[k], o - 8, din);
    if (v && !rnw && o == 16) m_ctrl[k] = din[1:0];
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    chk("dout_p4", 64'(bus4.d_out), 64'(m_dout[0]));
    chk("irq_p4",  64'(irq4),       64'(m_irq[0]));
    chk("dout_p1", 64'(bus1.d_out), 64'(m_dout[1]));
    chk("irq_p1",  64'(irq1),       64'(m_irq[1]));
  endtask

  task automatic idle(input int n);
    en = 1'b0;
    rdy = 1'b1;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wr_byte(input logic [4:0] o, input logic [7:0] d);
    en = 1'b1; rdy = 1'b1; rnw = 1'b0;
    addr = {12'($urandom), o};
    din = d;
    cycle();
    en = 1'b0; rnw = 1'b1;
  endtask

  task automatic rd_byte(input logic [4:0] o);
    en = 1'b1; rdy = 1'b1; rnw = 1'b1;
    addr = {12'($urandom), o};
    cycle();
    en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_dout4"}, 64'(bus4.d_out), 64'h0);
    chk({tag, "_irq4"},  64'(irq4),       64'h0);
    chk({tag, "_dout1"}, 64'(bus1.d_out), 64'h0);
    chk({tag, "_irq1"},  64'(irq1),       64'h0);
  endtask

  logic [63:0] saved_time;
  logic [7:0]  saved_dout;

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Reset contents of mtimecmp and ctrl.
    for (int i = 8; i < 16; i++) begin
      rd_byte(5'(i));
      chk("cmp_rst", 64'(bus1.d_out), 64'hFF);
    end
    rd_byte(5'h10);
    chk("ctrl_rst", 64'(bus4.d_out), 64'h00);

    // Run for 40 cycles at divide-by-4: ten ticks.
    wr_byte(5'h10, 8'h01);
    idle(40);
    rd_byte(5'h00);
    chk("tick40_range", 64'((bus4.d_out >= 8'h09) && (bus4.d_out <= 8'h0B)), 64'h1);

    // Carry across bit 32 on a single tick of the divide-by-1 instance.
    wr_byte(5'h10, 8'h00);
    for (int i = 0; i < 8; i++) wr_byte(5'(i), (i < 4) ? 8'hFF : 8'h00);
    wr_byte(5'h10, 8'h01);
    wr_byte(5'h10, 8'h00);
    begin
      logic [63:0] carry_exp;
      carry_exp = 64'h0000_0001_0000_0000;
      for (int i = 0; i < 8; i++) begin
        rd_byte(5'(i));
        chk("carry", 64'(bus1.d_out), (carry_exp >> (8 * i)) & 64'hFF);
      end
    end

    // Interrupt timing with mtimecmp = 5.
    for (int i = 0; i < 8; i++) wr_byte(5'(i), 8'h00);
    for (int i = 8; i < 16; i++) wr_byte(5'(i), (i == 8) ? 8'h05 : 8'h00);
    wr_byte(5'h10, 8'h03);
    for (int k = 1; k <= 8; k++) begin
      idle(1);
      chk("irq_rise", 64'(irq1), (k >= 6) ? 64'h1 : 64'h0);
    end
    wr_byte(5'h08, 8'h50);
    chk("irq_still_high", 64'(irq1), 64'h1);
    idle(1);
    chk("irq_drop_cmp", 64'(irq1), 64'h0);
    wr_byte(5'h08, 8'h05);
    wr_byte(5'h10, 8'h01);
    rd_byte(5'h11);
    chk("irq_ie_off", 64'(irq1), 64'h0);
    chk("status_pend", 64'(bus1.d_out), 64'h01);

    // Byte-1 boundary crossed between the reads of byte 0 and byte 1.
    wr_byte(5'h10, 8'h00);
    for (int i = 0; i < 8; i++) wr_byte(5'(i), (i == 0) ? 8'hFF : 8'h00);
    wr_byte(5'h10, 8'h01);
    rd_byte(5'h00);
    chk("snap_b0", 64'(bus1.d_out), 64'hFF);
    rd_byte(5'h01);
`ifdef MEM_TIMER_SNAPSHOT_EN
    chk("snap_b1", 64'(bus1.d_out), 64'h00);
`else
    chk("live_b1", 64'(bus1.d_out), 64'h01);
`endif
    wr_byte(5'h10, 8'h00);

    // Randomised bus traffic, model-checked every cycle.
    for (int i = 0; i < 400; i++) begin
      en   = 1'($urandom);
      rdy  = ($urandom_range(0, 7) != 0);
      rnw  = 1'($urandom);
      addr = 17'($urandom);
      din  = 8'($urandom);
      cycle();
    end
    idle(2);

    // Bus stalled while running with a write strobe held on mtime byte 0.
    wr_byte(5'h10, 8'h01);
    saved_time = m_time[1];
    saved_dout = m_dout[1];
    en = 1'b1; rnw = 1'b0; addr = 17'h00000; din = 8'h5A; rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk("stall_dout_hold", 64'(bus1.d_out), 64'(saved_dout));
    end
    rd_byte(5'h00);
    chk("stall_mtime", 64'(bus1.d_out), saved_time & 64'hFF);
    idle(5);

    // Asynchronous reset in the middle of a running cycle.
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    rd_byte(5'h0F);
    chk("midreset_cmp", 64'(bus4.d_out), 64'hFF);
    rd_byte(5'h10);
    chk("midreset_ctrl", 64'(bus1.d_out), 64'h00);
    rd_byte(5'h00);
    chk("midreset_mtime", 64'(bus4.d_out), 64'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_timer.md
# mem_timer

Memory-mapped machine timer that answers the CPU's byte-wide memory bus in the peripheral window (bus address bits [17:15] = 3'b101). It holds a 64-bit free-running `mtime` counter, a 64-bit `mtimecmp` compare register and a small control byte. It drives the level `timer_interrupt` input of `cpu`. Read data follows the same one-cycle registered latency as `ram`, so the top-level data mux treats it like RAM.

## Interface
- `ADDR_WIDTH`, 17: width of `a_in`; only `a_in[4:0]` is decoded.
- `PRESCALE`, 100: `clk` cycles per `mtime` tick, ≥1 (100 gives 1 µs at 100 MHz).

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rdy_in`  in  1  bus/CPU ready; low while HCI debug break is active.
- `en_in`  in  1  chip select from the top-level address decode.
- `r_nw_in`  in  1  1 = read, 0 = write.
- `a_in`  in  ADDR_WIDTH  byte address.
- `d_in`  in  8  write data.
- `d_out`  out  8  registered read data.
- `timer_interrupt`  out  1  level interrupt to the CPU.

## Operation
- Register map (`a_in[4:0]`, little-endian):
  - 0x00–0x07: `mtime`.
  - 0x08–0x0F: `mtimecmp`.
  - 0x10: `ctrl`. bit0 `run`, bit1 `ie`; other bits read 0.
  - 0x11: `status`, read-only. bit0 `pend` = (`mtime` ≥ `mtimecmp`).
  - 0x12–0x1F: read 0, writes ignored.
- Access is valid only when `en_in` & `rdy_in`.
- Write (valid & !`r_nw_in`): replaces exactly one byte of the addressed register.
- Read (valid & `r_nw_in`): loads `d_out` on the next edge. `d_out` holds its value at all other times.
- Prescaler: `pcnt` counts 0..PRESCALE-1 while `run`=1 and `rdy_in`=1, then wraps to 0.
  - `mtime` increments by 1 in the cycle `pcnt` wraps.
  - Writing `run`=0 freezes both `pcnt` and `mtime`.
- `mtime` wraps from 2^64-1 to 0 with no flag.
- A write to an `mtime` byte in the same cycle as a tick: the write wins for that byte, and no increment occurs that cycle. This is a whole-counter rule, so no carry is applied to the other bytes.
- Compare is unsigned over 64 bits.
- `timer_interrupt` is registered: `ie` & (`mtime` ≥ `mtimecmp`), sampled from the previous cycle's register values.
- Clearing the interrupt is done only by software: raise `mtimecmp` or clear `ie`.
- `rdy_in` low: bus accesses ignored, counter frozen, `timer_interrupt` holds its value.

## Timing
- Reset values:
  - `mtime` = 0, `pcnt` = 0.
  - `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF.
  - `ctrl` = 0, shadow = 0.
  - `d_out` = 0, `timer_interrupt` = 0.
- Read latency: 1 cycle. Address in cycle N, data valid on `d_out` in cycle N+1 (matches `ram`).
- Write takes effect at the end of cycle N. A read of the same byte in cycle N+1 returns the new value in cycle N+2.
- Interrupt latency: the first cycle with `mtime` ≥ `mtimecmp` (after a tick or a write) asserts `timer_interrupt` one edge later.
- Reset asserted mid-operation: all state returns to its reset value immediately (asynchronous). No partial write survives.

## Configuration
- `MEM_TIMER_SNAPSHOT_EN` defined:
  - A read of byte 0x00 copies `mtime[63:8]` into a 56-bit shadow register in the same cycle.
  - Reads of 0x01–0x07 return shadow bytes, giving a tear-free 64-bit read when bytes are read in ascending order.
  - Reads of `mtimecmp` are unaffected.
- Undefined: no shadow register. Every `mtime` byte read returns the live counter byte.

## Structure
- Shared package holds:
  - register offset constants: `TIMER_MTIME_OFF`=0x00, `TIMER_CMP_OFF`=0x08, `TIMER_CTRL_OFF`=0x10, `TIMER_STAT_OFF`=0x11;
  - `ctrl` bit indices;
  - the 64-bit reset value of `mtimecmp`;
  - the window decode constant 3'b101.
- One sub-module, `timer_prescaler`: parameterised divider that outputs a single-cycle `tick` and has an enable input. The register file, compare logic and read mux stay in `mem_timer`.

## Test plan
- Reset, then read 0x08–0x0F and 0x10: returns FF×8, then 0x00; `timer_interrupt`=0.
- PRESCALE=4, write `ctrl`=0x01, wait 40 cycles, read 0x00: returns 0x0A (±1 tick of alignment).
- Preload `mtime` = 0x0000_0000_FFFF_FFFF byte-wise, run 1 tick, read 0x00–0x07: returns FF→00 carry, giving 0x0000_0001_0000_0000.
- `mtimecmp`=5, `ctrl`=0x03, PRESCALE=1:
  - `timer_interrupt` rises exactly one cycle after `mtime` reaches 5.
  - Writing 0x08=0x50 drops it one cycle later.
  - `ctrl`=0x01 with `mtime` ≥ `mtimecmp` keeps it 0 while `status` reads 0x01.
- With `MEM_TIMER_SNAPSHOT_EN`: set `mtime`=0x00FF, tick across the byte-1 boundary between the reads of 0x00 and 0x01. Byte 1 reads 0x00 (shadow). Without the macro it reads 0x01.
- `rdy_in`=0 for 20 cycles while running with a write strobe asserted: `mtime` unchanged, write ignored, `d_out` holds its value. Reset pulsed mid-run: all outputs return to reset values.
